// File: rtl/accum_pkg.sv
// Shared types and helpers for the accumulator and add-family blocks.
package accum_pkg;

  typedef enum logic {
    ACCUM  = 1'b0,
    OUTPUT = 1'b1
  } accum_state_t;

  // Widest operand ext_to can handle; callers truncate the result to their own width.
  localparam int EXT_W = 64;

  // Extends the low 'width' bits of value to EXT_W bits, sign- or zero-filling the rest.
  function automatic logic [EXT_W-1:0] ext_to(input logic [EXT_W-1:0] value,
                                              input int                width,
                                              input bit                is_signed);
    logic [EXT_W-1:0] upper;
    logic [EXT_W-1:0] shifted;
    upper   = {EXT_W{1'b1}} << width;
    shifted = value >> (width - 1);
    if (is_signed && shifted[0]) begin
      return (value & ~upper) | upper;
    end
    return value & ~upper;
  endfunction

endpackage

// File: rtl/dti_s_if.sv
// Valid/ready element stream with an end-of-transaction marker.
interface dti_s_if #(
  parameter int W = 8
);
  logic [W-1:0] data;
  logic         dvalid;
  logic         dready;
  logic         eot;

  modport consumer(input data, input dvalid, input eot, output dready);
  modport producer(output data, output dvalid, output eot, input dready);
endinterface

// File: rtl/accum.sv
// Reduces each eot-terminated transaction on din to a single registered sum on dout.
module accum
  import accum_pkg::*;
#(
  parameter int TDIN       = 0,
  parameter int DIN_SIGNED = 0,
  parameter int CNT_WIDTH  = 4
) (
  input logic       clk,
  input logic       rst,
  dti_s_if.consumer din,
  dti_s_if.producer dout
);

  // Headroom bits let short transactions sum without wrapping; longer ones wrap silently.
  localparam int TDOUT = TDIN + CNT_WIDTH;

  accum_state_t     state_q, state_d;
  logic [TDOUT-1:0] acc_q, acc_d;
  logic [TDOUT-1:0] sum_q, sum_d;
  logic [TDOUT-1:0] din_ext;
  logic             din_hs;
  logic             dout_hs;

  // The sum register alone drives the output data, so it stays stable while stalled.
  assign dout.data = sum_q;
  assign dout.eot  = 1'b0;

  // State, running sum and output sum; reset discards any partial transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
    end
  end

  // Handshakes depend on state only, so input and output can never fire in the same cycle.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    din.dready  = 1'b0;
    dout.dvalid = 1'b0;
    din_hs      = 1'b0;
    dout_hs     = 1'b0;
    din_ext     = TDOUT'(ext_to(EXT_W'(din.data), TDIN, DIN_SIGNED != 0));

    case (state_q)
      ACCUM: begin
        din.dready = 1'b1;
        din_hs     = din.dvalid;
        if (din_hs) begin
          if (din.eot) begin
            sum_d   = acc_q + din_ext;
            acc_d   = '0;
            state_d = OUTPUT;
          end else begin
            acc_d = acc_q + din_ext;
          end
        end
      end
      OUTPUT: begin
        dout.dvalid = 1'b1;
        dout_hs     = dout.dready;
        if (dout_hs) begin
          state_d = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

endmodule

// File: tb/tb_accum.sv
// Drives one element stream into three accum variants (unsigned, signed, narrow headroom)
// and compares each sum against plain integer arithmetic over the accepted elements.
module tb_accum;

  logic       clk = 1'b0;
  logic       rst;
  logic       dvalid;
  logic [7:0] ddata;
  logic       deot;
  logic       dreadyDrv;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] modelQ[$];
  logic [31:0] expU, expS, expW;

  dti_s_if #(.W(8))  dinU();
  dti_s_if #(.W(12)) doutU();
  dti_s_if #(.W(8))  dinS();
  dti_s_if #(.W(12)) doutS();
  dti_s_if #(.W(8))  dinW();
  dti_s_if #(.W(9))  doutW();

  assign dinU.dvalid = dvalid;
  assign dinU.data   = ddata;
  assign dinU.eot    = deot;
  assign dinS.dvalid = dvalid;
  assign dinS.data   = ddata;
  assign dinS.eot    = deot;
  assign dinW.dvalid = dvalid;
  assign dinW.data   = ddata;
  assign dinW.eot    = deot;
  assign doutU.dready = dreadyDrv;
  assign doutS.dready = dreadyDrv;
  assign doutW.dready = dreadyDrv;

  accum #(.TDIN(8), .DIN_SIGNED(0), .CNT_WIDTH(4)) dutU (
    .clk(clk), .rst(rst), .din(dinU), .dout(doutU)
  );
  accum #(.TDIN(8), .DIN_SIGNED(1), .CNT_WIDTH(4)) dutS (
    .clk(clk), .rst(rst), .din(dinS), .dout(doutS)
  );
  accum #(.TDIN(8), .DIN_SIGNED(0), .CNT_WIDTH(1)) dutW (
    .clk(clk), .rst(rst), .din(dinW), .dout(doutW)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Hard stop in case the stimulus ever stalls
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Reference sums straight from the element list: integer sums reduced modulo the output width
  task automatic computeExpected();
    longint sumU = 0;
    longint sumS = 0;
    foreach (modelQ[i]) begin
      sumU += longint'(modelQ[i]);
      sumS += (modelQ[i] >= 8'd128) ? longint'(modelQ[i]) - 256 : longint'(modelQ[i]);
    end
    expU = 32'(sumU % 4096);
    expS = 32'(sumS & 64'hFFF);
    expW = 32'(sumU % 512);
    modelQ.delete();
  endtask

  task automatic checkSums(input string phase);
    checkOutput({phase, "_u_dvalid"}, 32'(doutU.dvalid), 32'd1);
    checkOutput({phase, "_u_data"}, 32'(doutU.data), expU);
    checkOutput({phase, "_s_data"}, 32'(doutS.data), expS);
    checkOutput({phase, "_w_data"}, 32'(doutW.data), expW);
    checkOutput({phase, "_din_dready"}, 32'(dinU.dready), 32'd0);
  endtask

  // Called one cycle after the eot handshake; holds off dready for 'stall' cycles
  task automatic collectSum(input int stall);
    computeExpected();
    checkSums("sum");
    for (int i = 0; i < stall; i++) begin
      dreadyDrv = 1'b0;
      @(posedge clk); #1;
      checkSums("stall");
    end
    dreadyDrv = 1'b1;
    @(posedge clk); #1;
    checkOutput("after_u_dvalid", 32'(doutU.dvalid), 32'd0);
    checkOutput("after_s_dvalid", 32'(doutS.dvalid), 32'd0);
    checkOutput("after_din_dready", 32'(dinW.dready), 32'd1);
    dreadyDrv = 1'(($urandom & 1));
  endtask

  // Presents one element, waits for acceptance, and collects the sum when it ends a transaction
  task automatic applyStimulus(input logic [7:0] d, input bit e, input int stall);
    int n = 0;
    dvalid = 1'b1;
    ddata  = d;
    deot   = e;
    @(negedge clk);
    while (dinU.dready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("din_dready_wait", 32'(dinU.dready), 32'd1);
    @(posedge clk); #1;
    dvalid = 1'b0;
    ddata  = 8'($urandom);
    deot   = 1'(($urandom & 1));
    modelQ.push_back(d);
    if (e) collectSum(stall);
  endtask

  // Idle cycle with garbage on data/eot that must be ignored
  task automatic bubble();
    dvalid = 1'b0;
    ddata  = 8'($urandom);
    deot   = 1'(($urandom & 1));
    @(posedge clk); #1;
  endtask

  initial begin
    rst       = 1'b1;
    dvalid    = 1'b0;
    ddata     = 8'h00;
    deot      = 1'b0;
    dreadyDrv = 1'b1;
    #1;
    checkOutput("reset_din_dready", 32'(dinU.dready), 32'd1);
    checkOutput("reset_dout_dvalid", 32'(doutU.dvalid), 32'd0);
    checkOutput("reset_dout_data", 32'(doutS.data), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] directed transactions");
    applyStimulus(8'd10, 1'b0, 0);
    applyStimulus(8'd20, 1'b0, 0);
    applyStimulus(8'd30, 1'b1, 0);
    applyStimulus(8'hFB, 1'b0, 0);
    applyStimulus(8'h03, 1'b0, 0);
    applyStimulus(8'hFF, 1'b1, 0);
    applyStimulus(8'hFF, 1'b1, 5);
    applyStimulus(8'd1, 1'b0, 0);
    applyStimulus(8'd2, 1'b1, 0);
    applyStimulus(8'd255, 1'b0, 0);
    bubble();
    applyStimulus(8'd255, 1'b0, 0);
    applyStimulus(8'd255, 1'b1, 1);

    $display("[TB] reset mid-transaction");
    applyStimulus(8'd7, 1'b0, 0);
    applyStimulus(8'd9, 1'b0, 0);
    rst = 1'b1;
    #1;
    checkOutput("midrst_dout_dvalid", 32'(doutU.dvalid), 32'd0);
    checkOutput("midrst_din_dready", 32'(dinU.dready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    modelQ.delete();
    applyStimulus(8'd4, 1'b1, 0);

    $display("[TB] random transactions");
    for (int t = 0; t < 40; t++) begin
      int len;
      len = int'($urandom_range(1, 20));
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) bubble();
        applyStimulus(8'($urandom), k == len - 1, int'($urandom_range(0, 4)));
      end
    end

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/accum.md
# accum

Stream accumulator placed directly downstream of `add`. It consumes a `dti_s_if` stream of numbers grouped into transactions, where `din.eot` marks the last element. For each transaction it emits exactly one registered sum on `dout`, so a chain of `add` results can be reduced to one value per transaction. It is a two-state handshake FSM with one accumulator register and one output register.

## Interface
Parameters:
- `TDIN`, 0: `din.data` width in bits; must be ≥1.
- `DIN_SIGNED`, 0: 1 means `din.data` is two's-complement.
- `CNT_WIDTH`, 4: growth headroom; `TDOUT = TDIN + CNT_WIDTH`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `din`, `dti_s_if.consumer`, TDIN: element stream; `din.eot` = last element of the transaction.
- `dout`, `dti_s_if.producer`, TDOUT: one sum per transaction.

## Operation
- Extension:
  - `DIN_SIGNED=1`: `din.data` is sign-extended to TDOUT.
  - `DIN_SIGNED=0`: `din.data` is zero-extended to TDOUT.
- Arithmetic is modulo 2^TDOUT. There is no saturation and no overflow flag.
- Handshake definitions: `din_hs = din.dvalid & din.dready`; `dout_hs = dout.dvalid & dout.dready`.
- FSM states: ACCUM (reset state) and OUTPUT.
- In ACCUM:
  - `din.dready=1`, `dout.dvalid=0`.
  - On `din_hs` with `eot=0`: `acc <= acc + ext(din.data)`.
  - On `din_hs` with `eot=1`: `sum_q <= acc + ext(din.data)`, `acc <= 0`, go to OUTPUT.
- In OUTPUT:
  - `din.dready=0`, `dout.dvalid=1`, `dout.data=sum_q`.
  - `dout.data` is held stable until `dout_hs`.
  - On `dout_hs`: go to ACCUM.
- `dout.eot` is tied to 0.
- Outputs are driven only from registers and state. There is no combinational path from `din.dvalid` to `dout.dvalid`.
- `din.dready` is a function of state only, independent of `dout.dready`.
- Single-element transaction (`eot=1` on the first element): the output equals that element, extended.
- Transaction longer than 2^CNT_WIDTH elements: the sum wraps modulo 2^TDOUT. This is legal and is not flagged.
- Reset values:
  - Internal: state=ACCUM, `acc=0`, `sum_q=0`.
  - Outputs: `din.dready=1`, `dout.dvalid=0`, `dout.data=0`.
- Reset mid-transaction: the partial sum is discarded. Upstream must restart the transaction after reset.
- `din.data` and `din.eot` are ignored when `din.dvalid=0`.

## Timing
- Latency: the `din_hs` with `eot=1` in cycle N gives `dout.dvalid=1` in cycle N+1.
- Throughput: a transaction of L elements occupies at least L+1 cycles (L input cycles plus at least one output cycle).
- Back-to-back: the cycle after `dout_hs`, `din.dready=1` and the next transaction's first element may be accepted.
- No simultaneous `din_hs` and `dout_hs` in the same cycle; the FSM makes this impossible by construction.
- Downstream stall: OUTPUT persists indefinitely with `dout.data` stable.
- Upstream bubbles: ACCUM holds `acc` unchanged while `din.dvalid=0`.

## Structure
- Shared package `accum_pkg` holds:
  - the state enum `accum_state_t` {ACCUM, OUTPUT};
  - a function `ext_to(width, signed)` for extension, so it can be reused by `add`-family blocks.
- `TDOUT` is a localparam inside the module.
- No sub-module; a single module with one `always_ff` (async reset) and one `always_comb`.

## Test plan
- Unsigned, TDIN=8, CNT_WIDTH=4: stream 10, 20, 30(eot) with dout.dready=1
  - `dout.data=60` exactly one cycle after the eot handshake.
  - `dout.dvalid` high for exactly one cycle.
- Signed, TDIN=8: stream -5 (0xFB), 3, -1 (0xFF, eot)
  - `dout.data` = 12'hFFD (−3).
- Single element 0xFF with eot, unsigned
  - `dout.data=12'h0FF`.
  - Repeat with DIN_SIGNED=1: `dout.data=12'hFFF`.
- Backpressure: hold `dout.dready=0` for 5 cycles after the sum appears
  - `din.dready=0` and `dout.data` stable throughout.
  - Release: handshake, then the next transaction (1, 2(eot)) gives 3.
- Wrap: TDIN=8, CNT_WIDTH=1, stream 255, 255, 255(eot)
  - `dout.data = 765 mod 512 = 253`.
- Reset mid-transaction: feed 7, 9, assert `rst` for 1 cycle, then feed 4(eot)
  - `dout.data=4`.
  - During reset: `dout.dvalid=0` and `din.dready=1`.
